sa_cache_fsm: RTL and testbench

//  N-way set-associative, write-back, write-allocate cache controller with

---
 rtl/sa_cache_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_sa_cache_fsm.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_cache_fsm.sv
// Set-associative write-back, write-allocate cache controller with LRU/MRU replacement.
// Tags, valid/dirty bits, ages and line data live in per-set register arrays.
module sa_cache_fsm #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned SETS       = 1024,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REPL       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_req_valid,
    input  logic                         cpu_req_rw,
    input  logic [ADDR_W-1:0]            cpu_req_addr,
    input  logic [DATA_W-1:0]            cpu_req_data,
    output logic                         cpu_res_ready,
    output logic [DATA_W-1:0]            cpu_res_data,
    output logic                         mem_req_valid,
    output logic                         mem_req_rw,
    output logic [ADDR_W-1:0]            mem_req_addr,
    output logic [LINE_WORDS*DATA_W-1:0] mem_req_data,
    input  logic                         mem_data_ready,
    input  logic [LINE_WORDS*DATA_W-1:0] mem_data_data
);

    localparam int unsigned LINE_W = LINE_WORDS * DATA_W;
    localparam int unsigned OFF    = $clog2(LINE_W / 8);
    localparam int unsigned IDX    = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - OFF - IDX;
    localparam int unsigned BYTE_W = $clog2(DATA_W / 8);
    localparam int unsigned WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WAY_W-1:0] REPL_AGE = (REPL != 0 || WAYS == 1) ? '0 : WAY_W'(WAYS - 1);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

    state_t             state_q, state_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;

    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    dirty_q [SETS];
    logic [WAY_W-1:0]   age_q   [SETS][WAYS];
    logic [DATA_W-1:0]  data_q  [SETS][WAYS][LINE_WORDS];

    logic [TAG_W-1:0]   req_tag;
    logic [IDX-1:0]     req_idx;
    logic [WSEL_W-1:0]  word_sel;
    logic [WAYS-1:0]    set_valid;
    logic [WAYS-1:0]    set_dirty;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   hit_age;
    logic [WAY_W-1:0]   victim_w;
    logic               inv_found;
    logic [LINE_W-1:0]  victim_line;
    logic               acc_done;
    logic               install;
    logic               fill;
    logic               unused_addr;

    assign req_tag     = cpu_req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx     = cpu_req_addr[OFF +: IDX];
    assign set_valid   = valid_q[req_idx];
    assign set_dirty   = dirty_q[req_idx];
    assign hit_age     = age_q[req_idx][hit_way];
    assign unused_addr = ^cpu_req_addr[BYTE_W-1:0];

    if (LINE_WORDS > 1) begin : g_wsel
        assign word_sel = cpu_req_addr[OFF-1:BYTE_W];
    end else begin : g_wsel_one
        assign word_sel = '0;
    end

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (set_valid[w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way wins; with a full set the age policy picks the victim.
    always_comb begin
        victim_w  = '0;
        inv_found = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!inv_found && !set_valid[w]) begin
                victim_w  = WAY_W'(w);
                inv_found = 1'b1;
            end
        end
        if (!inv_found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[req_idx][w] == REPL_AGE) begin
                    victim_w = WAY_W'(w);
                end
            end
        end
    end

    always_comb begin
        victim_line = '0;
        for (int unsigned k = 0; k < LINE_WORDS; k++) begin
            victim_line[k*DATA_W +: DATA_W] = data_q[req_idx][victim_q][k];
        end
    end

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        wb_tag_d      = wb_tag_q;
        cpu_res_ready = 1'b0;
        cpu_res_data  = '0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        acc_done      = 1'b0;
        install       = 1'b0;
        fill          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_valid) state_d = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    cpu_res_ready = 1'b1;
                    cpu_res_data  = data_q[req_idx][hit_way][word_sel];
                    acc_done      = 1'b1;
                    state_d       = IDLE;
                end else begin
                    install  = 1'b1;
                    victim_d = victim_w;
                    wb_tag_d = tag_q[req_idx][victim_w];
                    state_d  = (set_valid[victim_w] && set_dirty[victim_w]) ? WRITE_BACK : ALLOCATE;
                end
            end
            WRITE_BACK: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {wb_tag_q, req_idx, {OFF{1'b0}}};
                mem_req_data  = victim_line;
                if (mem_data_ready) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_idx, {OFF{1'b0}}};
                if (mem_data_ready) begin
                    fill    = 1'b1;
                    state_d = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
            wb_tag_q <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            wb_tag_q <= wb_tag_d;
            if (acc_done) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == hit_way) begin
                        age_q[req_idx][w] <= '0;
                    end else if (age_q[req_idx][w] < hit_age) begin
                        age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
                    end
                end
                if (cpu_req_rw) dirty_q[req_idx][hit_way] <= 1'b1;
            end
            // Tag is claimed at the miss; the old tag is kept in wb_tag_q for write-back.
            if (install) begin
                valid_q[req_idx][victim_w] <= 1'b1;
                dirty_q[req_idx][victim_w] <= 1'b0;
                tag_q[req_idx][victim_w]   <= req_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc_done && cpu_req_rw) begin
            data_q[req_idx][hit_way][word_sel] <= cpu_req_data;
        end
        if (fill) begin
            for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                data_q[req_idx][victim_q][k] <= mem_data_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_sa_cache_fsm.sv
// Scoreboard bench for sa_cache_fsm: an LRU instance and an MRU instance, each with a
// memory responder that answers every request three cycles after it appears.
module tb_sa_cache_fsm;

    typedef struct {
        int          dut;
        logic        chk;
        logic [31:0] addr;
        logic [31:0] data;
    } cpu_exp_t;

    typedef struct {
        int           dut;
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] line;
    } mem_exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid [2];
    logic         req_rw    [2];
    logic [31:0]  req_addr  [2];
    logic [31:0]  req_data  [2];
    logic         res_ready [2];
    logic [31:0]  res_data  [2];
    logic         mreq_valid[2];
    logic         mreq_rw   [2];
    logic [31:0]  mreq_addr [2];
    logic [127:0] mreq_data [2];
    logic         mready    [2];
    logic [127:0] mdata     [2];
    int           mcnt      [2];

    cpu_exp_t cq[$];
    mem_exp_t mq[$];
    cpu_exp_t ce;
    mem_exp_t me;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sa_cache_fsm #(.WAYS(4), .SETS(1024), .LINE_WORDS(4), .ADDR_W(32), .DATA_W(32), .REPL(0)) u_lru (
        .clk(clk), .rst(rst),
        .cpu_req_valid(req_valid[0]), .cpu_req_rw(req_rw[0]), .cpu_req_addr(req_addr[0]),
        .cpu_req_data(req_data[0]), .cpu_res_ready(res_ready[0]), .cpu_res_data(res_data[0]),
        .mem_req_valid(mreq_valid[0]), .mem_req_rw(mreq_rw[0]), .mem_req_addr(mreq_addr[0]),
        .mem_req_data(mreq_data[0]), .mem_data_ready(mready[0]), .mem_data_data(mdata[0])
    );

    sa_cache_fsm #(.WAYS(4), .SETS(1024), .LINE_WORDS(4), .ADDR_W(32), .DATA_W(32), .REPL(1)) u_mru (
        .clk(clk), .rst(rst),
        .cpu_req_valid(req_valid[1]), .cpu_req_rw(req_rw[1]), .cpu_req_addr(req_addr[1]),
        .cpu_req_data(req_data[1]), .cpu_res_ready(res_ready[1]), .cpu_res_data(res_data[1]),
        .mem_req_valid(mreq_valid[1]), .mem_req_rw(mreq_rw[1]), .mem_req_addr(mreq_addr[1]),
        .mem_req_data(mreq_data[1]), .mem_data_ready(mready[1]), .mem_data_data(mdata[1])
    );

    // Fill word k of a line: 0x1000 yields {4,3,2,1}, 0x4000 yields {5004,5003,5002,5001}.
    function automatic logic [31:0] fw(input logic [31:0] la, input int k);
        return (la ^ 32'h1000) + 32'(k) + 32'd1;
    endfunction

    function automatic logic [127:0] fill_line(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = fw(la, k);
        return l;
    endfunction

    task automatic exp_mem(input int d, input logic rw, input logic [31:0] addr, input logic [127:0] line);
        mem_exp_t e;
        e.dut = d; e.rw = rw; e.addr = addr; e.line = line;
        mq.push_back(e);
    endtask

    task automatic access(input int d, input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input logic chk, input int lat);
        cpu_exp_t e;
        int cyc;
        logic seen;
        e.dut = d; e.chk = chk; e.addr = addr; e.data = exp;
        cq.push_back(e);
        @(negedge clk);
        req_rw[d] = rw; req_addr[d] = addr; req_data[d] = wdata; req_valid[d] = 1'b1;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            seen = res_ready[d];
        end
        req_valid[d] = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout dut%0d addr %h: no response within %0d cycles", d, addr, cyc);
        end else if (cyc != lat) begin
            errors++;
            $display("FAIL latency dut%0d addr %h: got %0d cycles, expected %0d", d, addr, cyc, lat);
        end
    endtask

    task automatic check_idle(input int d, input string nm);
        checks++;
        if ({res_ready[d], res_data[d], mreq_valid[d], mreq_rw[d], mreq_addr[d], mreq_data[d]} !== '0) begin
            errors++;
            $display("FAIL %s dut%0d: got res_ready=%b res_data=%h mem_valid=%b rw=%b addr=%h, expected all 0",
                     nm, d, res_ready[d], res_data[d], mreq_valid[d], mreq_rw[d], mreq_addr[d]);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_rw[d] = 1'b0; req_addr[d] = '0; req_data[d] = '0;
            mready[d] = 1'b0; mdata[d] = '0; mcnt[d] = 0;
        end

        fork
            forever begin
                @(negedge clk);
                for (int d = 0; d < 2; d++) begin
                    if (rst) begin
                        mready[d] = 1'b0;
                        mcnt[d] = 0;
                    end else if (mready[d]) begin
                        mready[d] = 1'b0;
                    end else if (mreq_valid[d]) begin
                        mcnt[d]++;
                        if (mcnt[d] == 3) begin
                            mcnt[d] = 0;
                            checks++;
                            if (mq.size() == 0) begin
                                errors++;
                                $display("FAIL mem_unexpected dut%0d: got rw=%b addr=%h, expected no request",
                                         d, mreq_rw[d], mreq_addr[d]);
                            end else begin
                                me = mq.pop_front();
                                if (me.dut != d || me.rw !== mreq_rw[d] || me.addr !== mreq_addr[d] ||
                                    (me.rw && me.line !== mreq_data[d])) begin
                                    errors++;
                                    $display("FAIL mem_req dut%0d: got rw=%b addr=%h data=%h, expected dut%0d rw=%b addr=%h data=%h",
                                             d, mreq_rw[d], mreq_addr[d], mreq_data[d], me.dut, me.rw, me.addr,
                                             me.rw ? me.line : mreq_data[d]);
                                end
                            end
                            mdata[d] = fill_line(mreq_addr[d]);
                            mready[d] = 1'b1;
                        end
                    end else begin
                        mcnt[d] = 0;
                    end

                    if (res_ready[d]) begin
                        checks++;
                        if (cq.size() == 0) begin
                            errors++;
                            $display("FAIL cpu_unexpected dut%0d: got data %h, expected no response", d, res_data[d]);
                        end else begin
                            ce = cq.pop_front();
                            if (ce.dut != d || (ce.chk && res_data[d] !== ce.data)) begin
                                errors++;
                                $display("FAIL cpu_data dut%0d addr %h: got %h, expected %h (dut%0d)",
                                         d, ce.addr, res_data[d], ce.data, ce.dut);
                            end
                        end
                    end
                end
            end
            begin
                repeat (50000) @(posedge clk);
                $display("FAIL watchdog: bench did not finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle(0, "reset");
        check_idle(1, "reset");

        // Cold read miss then hit-after-write on the same word.
        exp_mem(0, 1'b0, 32'h1000, '0);
        access(0, 1'b0, 32'h1004, '0, 32'd2, 1'b1, 5);
        access(0, 1'b1, 32'h1004, 32'hDEADBEEF, '0, 1'b0, 1);
        access(0, 1'b0, 32'h1004, '0, 32'hDEADBEEF, 1'b1, 1);

        // LRU: set 0 ways 0..3 = 0x0, 0x4000, 0x8000, 0xC000.
        exp_mem(0, 1'b0, 32'h0000, '0);  access(0, 1'b0, 32'h0000, '0, 32'h1001, 1'b1, 5);
        exp_mem(0, 1'b0, 32'h4000, '0);  access(0, 1'b0, 32'h4000, '0, 32'h5001, 1'b1, 5);
        exp_mem(0, 1'b0, 32'h8000, '0);  access(0, 1'b0, 32'h8000, '0, 32'h9001, 1'b1, 5);
        exp_mem(0, 1'b0, 32'hC000, '0);  access(0, 1'b0, 32'hC000, '0, 32'hD001, 1'b1, 5);
        access(0, 1'b0, 32'h0000, '0, 32'h1001, 1'b1, 1);
        exp_mem(0, 1'b0, 32'h10000, '0); access(0, 1'b0, 32'h10000, '0, 32'h11001, 1'b1, 5);
        exp_mem(0, 1'b0, 32'h4000, '0);  access(0, 1'b0, 32'h4000, '0, 32'h5001, 1'b1, 5);
        access(0, 1'b0, 32'h0000, '0, 32'h1001, 1'b1, 1);

        // Dirty eviction of 0x4000 (way 2): age it to 3, then miss on a new tag.
        access(0, 1'b1, 32'h4000, 32'h55, '0, 1'b0, 1);
        access(0, 1'b0, 32'h10000, '0, 32'h11001, 1'b1, 1);
        access(0, 1'b0, 32'hC000, '0, 32'hD001, 1'b1, 1);
        access(0, 1'b0, 32'h0000, '0, 32'h1001, 1'b1, 1);
        exp_mem(0, 1'b1, 32'h4000, {32'h5004, 32'h5003, 32'h5002, 32'h55});
        exp_mem(0, 1'b0, 32'h24000, '0);
        access(0, 1'b0, 32'h24000, '0, 32'h25001, 1'b1, 9);

        // MRU instance, same set-0 sequence.
        exp_mem(1, 1'b0, 32'h0000, '0);  access(1, 1'b0, 32'h0000, '0, 32'h1001, 1'b1, 5);
        exp_mem(1, 1'b0, 32'h4000, '0);  access(1, 1'b0, 32'h4000, '0, 32'h5001, 1'b1, 5);
        exp_mem(1, 1'b0, 32'h8000, '0);  access(1, 1'b0, 32'h8000, '0, 32'h9001, 1'b1, 5);
        exp_mem(1, 1'b0, 32'hC000, '0);  access(1, 1'b0, 32'hC000, '0, 32'hD001, 1'b1, 5);
        access(1, 1'b0, 32'h0000, '0, 32'h1001, 1'b1, 1);
        exp_mem(1, 1'b0, 32'h10000, '0); access(1, 1'b0, 32'h10000, '0, 32'h11001, 1'b1, 5);
        access(1, 1'b0, 32'h4000, '0, 32'h5001, 1'b1, 1);
        exp_mem(1, 1'b0, 32'h0000, '0);  access(1, 1'b0, 32'h0000, '0, 32'h1001, 1'b1, 5);

        // Reset while ALLOCATE is pending.
        @(negedge clk);
        req_rw[0] = 1'b0; req_addr[0] = 32'h2008; req_data[0] = '0; req_valid[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (!(mreq_valid[0] === 1'b1 && mreq_rw[0] === 1'b0 && mreq_addr[0] === 32'h2000)) begin
            errors++;
            $display("FAIL alloc_pending: got valid=%b rw=%b addr=%h, expected valid=1 rw=0 addr=00002000",
                     mreq_valid[0], mreq_rw[0], mreq_addr[0]);
        end
        rst = 1'b1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_idle(0, "reset_in_alloc");
        check_idle(1, "reset_in_alloc");
        rst = 1'b0;
        exp_mem(0, 1'b0, 32'h2000, '0);
        access(0, 1'b0, 32'h2008, '0, 32'h3003, 1'b1, 5);

        repeat (6) @(negedge clk);
        checks++;
        if (cq.size() != 0) begin
            errors++;
            $display("FAIL cpu_pending: got %0d unanswered requests, expected 0", cq.size());
        end
        checks++;
        if (mq.size() != 0) begin
            errors++;
            $display("FAIL mem_pending: got %0d missing memory requests, expected 0", mq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
